trng_sampler: RTL and testbench



---
 rtl/trng_sampler.sv | 148 ++++++++++++++
 tb/tb_trng_sampler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/trng_sampler.sv
// Ring-oscillator consumer: oscillator enable, raw-bit synchronizer, divided sampling,
// von Neumann debiasing and byte packing on a valid/ready port. Define TRNG_HEALTH_EN for the repetition-count health test.
module trng_sampler #(
  parameter int SYNC_STAGES   = 2,
  parameter int SAMPLE_DIV    = 8,
  parameter int WARMUP_CYCLES = 16,
  parameter int RC_LIMIT      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ro_in,
  output logic       ro_activate,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       health_fail
);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WRM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  if (SYNC_STAGES < 2 || SAMPLE_DIV < 1 || WARMUP_CYCLES < 1 || RC_LIMIT < 2) begin : g_param_check
    $error("trng_sampler: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COLLECT,
    S_HOLD
`ifdef TRNG_HEALTH_EN
    , S_FAIL
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic [DIV_W-1:0]       div_q;
  logic [WRM_W-1:0]       wcnt_q;
  logic                   phase_q, first_q;
  logic [2:0]             bitcnt_q;
  logic [7:0]             data_q;
  logic                   strobe, emit, byte_done, rc_trip, in_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
  end
  assign sync_bit = sync_q[SYNC_STAGES-1];

  // en is folded into the strobe so the edge that drops en never shifts a bit in.
  assign strobe    = (state_q == S_COLLECT) && en && (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign emit      = strobe && phase_q && (first_q != sync_bit) && !rc_trip;
  assign byte_done = emit && (bitcnt_q == 3'd7);

`ifdef TRNG_HEALTH_EN
  localparam int RC_W = $clog2(RC_LIMIT + 1);
  logic [RC_W-1:0] rc_cnt_q, rc_next;
  logic            rc_val_q, rc_fresh_q;

  // Raw samples, before correction; the run restarts after every warmup.
  assign rc_next = (rc_fresh_q || (sync_bit != rc_val_q)) ? RC_W'(1) : rc_cnt_q + 1'b1;
  assign rc_trip = strobe && (rc_next == RC_W'(RC_LIMIT));
  assign in_fail = (state_q == S_FAIL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_cnt_q   <= '0;
      rc_val_q   <= 1'b0;
      rc_fresh_q <= 1'b0;
    end else begin
      if (state_q == S_WARMUP) rc_fresh_q <= 1'b1;
      else if (strobe)         rc_fresh_q <= 1'b0;
      if (strobe) begin
        rc_cnt_q <= rc_next;
        rc_val_q <= sync_bit;
      end
    end
  end
`else
  assign rc_trip = 1'b0;
  assign in_fail = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ro_activate = 1'b0;
    out_valid   = 1'b0;
    health_fail = 1'b0;
    case (state_q)
      S_IDLE: if (en) state_d = S_WARMUP;
      S_WARMUP: begin
        ro_activate = 1'b1;
        if (wcnt_q == WRM_W'(WARMUP_CYCLES - 1)) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        ro_activate = 1'b1;
`ifdef TRNG_HEALTH_EN
        if (rc_trip) state_d = S_FAIL;
        else
`endif
        if (byte_done) state_d = S_HOLD;
      end
      S_HOLD: begin
        ro_activate = 1'b1;
        out_valid   = 1'b1;
        if (out_ready) state_d = S_COLLECT;
      end
`ifdef TRNG_HEALTH_EN
      S_FAIL: health_fail = 1'b1;
`endif
      default: state_d = S_IDLE;
    endcase
    // Dropping en wins over everything except a latched health failure.
    if (!en && !in_fail) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      wcnt_q   <= '0;
      phase_q  <= 1'b0;
      first_q  <= 1'b0;
      bitcnt_q <= 3'd0;
      data_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      wcnt_q  <= (state_q == S_WARMUP) ? wcnt_q + 1'b1 : '0;
      // Divider restarts from 0 on every entry to COLLECT and sits at 0 elsewhere.
      if (state_q == S_COLLECT && state_d == S_COLLECT) div_q <= strobe ? '0 : div_q + 1'b1;
      else                                              div_q <= '0;
      if (state_q != S_COLLECT) begin
        phase_q  <= 1'b0;
        bitcnt_q <= 3'd0;
      end else if (strobe) begin
        phase_q <= !phase_q;
        if (!phase_q) first_q <= sync_bit;
        if (emit)     bitcnt_q <= bitcnt_q + 1'b1;
      end
      if (emit) data_q <= {data_q[6:0], first_q};
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_trng_sampler.sv
// Directed + random bench for trng_sampler against a sample-schedule reference model.
module tb_trng_sampler;
  localparam int SYNC = 2;
  localparam int DIV  = 3;
  localparam int W    = 5;
  localparam int RC   = 32;
`ifdef TRNG_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif
  localparam int M_IDLE = 0, M_WARM = 1, M_COLL = 2, M_HOLD = 3, M_FAIL = 4;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, ro_in = 1'b0, out_ready = 1'b0;
  logic       ro_activate, out_valid, health_fail;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  trng_sampler #(.SYNC_STAGES(SYNC), .SAMPLE_DIV(DIV), .WARMUP_CYCLES(W), .RC_LIMIT(RC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ro_in(ro_in), .ro_activate(ro_activate),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .health_fail(health_fail)
  );

  int n_assert = 0, n_fail = 0;

  // Reference: absolute edge index, raw-bit history, strobes at m_s + k*DIV.
  int         m_st, m_s, m_e, m_wleft, m_nbits, m_rc;
  bit         m_have_a, m_a, m_rc_first, m_rc_val, m_hf;
  logic [7:0] m_data;
  bit         hq[$];
  int         mode;
  bit         plan[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st = M_IDLE; m_data = 8'h00; m_hf = 0; m_nbits = 0; m_have_a = 0;
    m_rc = 0; m_rc_first = 0; m_rc_val = 0;
    hq.delete();
    repeat (SYNC) hq.push_back(1'b0);
  endtask

  task automatic m_edge(input bit e_en, input bit e_rdy, input bit e_ro);
    bit b;
    hq.push_back(e_ro);
    if (hq.size() > SYNC + 1) void'(hq.pop_front());
    b = hq[0];
    if (m_st == M_FAIL) begin
    end else if (!e_en) begin
      m_st = M_IDLE; m_nbits = 0; m_have_a = 0;
    end else begin
      case (m_st)
        M_IDLE: begin m_st = M_WARM; m_wleft = W; m_s = m_e + W; end
        M_WARM: begin
          m_wleft--;
          if (m_wleft == 0) begin m_st = M_COLL; m_rc_first = 1; end
        end
        M_COLL: if (m_e > m_s && (m_e - m_s) % DIV == 0) begin
          m_rc = (m_rc_first || b != m_rc_val) ? 1 : m_rc + 1;
          m_rc_val = b; m_rc_first = 0;
          if (HEALTH && m_rc >= RC) begin
            m_st = M_FAIL; m_hf = 1;
          end else if (!m_have_a) begin
            m_a = b; m_have_a = 1;
          end else begin
            m_have_a = 0;
            if (m_a != b) begin
              m_data = {m_data[6:0], m_a};
              m_nbits++;
              if (m_nbits == 8) begin m_nbits = 0; m_st = M_HOLD; end
            end
          end
        end
        M_HOLD: if (e_rdy) begin m_st = M_COLL; m_s = m_e; m_have_a = 0; end
        default: ;
      endcase
    end
    m_e++;
  endtask

  // Raw bit driven at the upcoming edge; in plan mode it lands on sample index idx.
  function automatic bit ro_val();
    int num;
    case (mode)
      1: begin
        num = m_e + SYNC - m_s - 1;
        if (num < 0) return 1'b0;
        return (num / DIV < plan.size()) ? plan[num / DIV] : 1'b0;
      end
      2: return 1'b1;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic step(input bit s_en, input bit s_rdy);
    bit r;
    @(negedge clk);
    r = ro_val();
    en = s_en; out_ready = s_rdy; ro_in = r;
    m_edge(s_en, s_rdy, r);
    @(posedge clk); #1;
    chk("ro_activate", {7'b0, ro_activate}, {7'b0, (m_st == M_WARM || m_st == M_COLL || m_st == M_HOLD)});
    chk("out_valid",   {7'b0, out_valid},   {7'b0, (m_st == M_HOLD)});
    chk("health_fail", {7'b0, health_fail}, {7'b0, m_hf});
    chk("out_data",    out_data,            m_data);
  endtask

  task automatic wait_byte(input bit rdy, input int budget);
    int n = 0;
    while (m_st != M_HOLD && n < budget) begin step(1'b1, rdy); n++; end
    chk("byte_ready", {7'b0, out_valid}, 8'h01);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ro_activate"}, {7'b0, ro_activate}, 8'h00);
    chk({tag, "_out_valid"},   {7'b0, out_valid},   8'h00);
    chk({tag, "_out_data"},    out_data,            8'h00);
    chk({tag, "_health_fail"}, {7'b0, health_fail}, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    int n;
    m_e = 0; m_s = 0; mode = 0;
    m_reset();
    #2 chk_reset_vals("por");
    #20;
    @(negedge clk) rst_n = 1'b1;

    // Pairs 10,00,01,11,10,01,01,10,01,10 -> bits 1,0,1,0,0,1,0,1
    plan = '{1,0, 0,0, 0,1, 1,1, 1,0, 0,1, 0,1, 1,0, 0,1, 1,0};
    mode = 1;
    wait_byte(1'b1, 200);
    chk("a5_byte", out_data, 8'hA5);

    plan = '{0,1, 0,1, 0,1, 0,1, 0,1, 0,1, 0,1, 0,1};
    step(1'b1, 1'b1);
    wait_byte(1'b1, 200);
    chk("zero_byte", out_data, 8'h00);

    plan = '{1,0, 1,0, 1,0, 1,0, 1,0, 1,0, 1,0, 1,0};
    step(1'b1, 1'b1);
    wait_byte(1'b1, 200);
    chk("ones_byte", out_data, 8'hFF);

    // Backpressure on a random byte
    mode = 0;
    step(1'b1, 1'b1);
    wait_byte(1'b0, 1000);
    held = out_data;
    repeat (50) step(1'b1, 1'b0);
    chk("bp_stable", out_data, held);
    chk("bp_still_valid", {7'b0, out_valid}, 8'h01);
    step(1'b1, 1'b1);
    chk("bp_released", {7'b0, out_valid}, 8'h00);
    wait_byte(1'b0, 1000);

    // Drop en after 5 corrected bits; the next byte must be all fresh samples
    step(1'b1, 1'b1);
    n = 0;
    while (m_nbits != 5 && n < 1000) begin step(1'b1, 1'b0); n++; end
    step(1'b0, 1'b0);
    chk("drop_ro_off", {7'b0, ro_activate}, 8'h00);
    repeat (3) step(1'b0, 1'b0);
    plan = '{1,0, 0,0, 0,1, 1,1, 1,0, 0,1, 0,1, 1,0, 0,1, 1,0};
    mode = 1;
    wait_byte(1'b1, 200);
    chk("reenable_byte", out_data, 8'hA5);

    mode = 0;
    repeat (1500) step(($urandom % 100) != 0, ($urandom % 3) != 0);

    // Async reset mid-warmup
    step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid_warmup_rst");
    m_reset();
    @(negedge clk) rst_n = 1'b1;

    // Stuck-at-1 oscillator
    mode = 2;
    repeat (W + RC * DIV + 20) step(1'b1, 1'b1);
    chk("stuck_health", {7'b0, health_fail}, {7'b0, HEALTH});
    chk("stuck_no_byte", {7'b0, out_valid}, 8'h00);
    chk("stuck_ro_act", {7'b0, ro_activate}, {7'b0, !HEALTH});
    step(1'b0, 1'b0);
    chk("stuck_sticky", {7'b0, health_fail}, {7'b0, HEALTH});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
